frog_ctrl: RTL and testbench
============================

# frog_ctrl

Frog movement controller: turns player button presses and collision events into the registered `frog_x`, `frog_y` and `facing` values that drive the frog sprite renderer. Hops are applied on frame ticks so the position never changes mid-frame, and edge bounds are enforced. The block also sequences death, respawn and optionally a lives counter. It sits between the input synchronizers and the frog sprite generator, and the collision logic feeds it.

## Interface
- `FROG_SIZE`, 32: sprite edge in pixels (informational; bounds below are top-left coordinates).
- `STEP`, 32: pixels per hop.
- `HOP_FRAMES`, 4: ticks per hop; `STEP` must be divisible by `HOP_FRAMES`.
- `X_MIN` / `X_MAX`, 0 / 608: legal top-left x range, inclusive.
- `Y_MIN` / `Y_MAX`, 0 / 448: legal top-left y range, inclusive.
- `START_X` / `START_Y`, 304 / 448: spawn position.
- `DEAD_FRAMES`, 60: ticks spent in the death state.
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `tick` in 1: one-cycle frame pulse, once per vsync.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: already-synchronized button levels.
- `kill` in 1: one-cycle collision pulse.
- `frog_x`, `frog_y` out 10: sprite top-left position.
- `facing` out 2: 00 up, 01 right, 10 down, 11 left (sprite ROM bank select).
- `hopping` out 1: high while a hop is in progress.
- `dead` out 1: high in the DEAD state.
- `lives` out 2: remaining lives.
- `game_over` out 1: sticky until reset.

## Operation
- **Press capture**
  - Each button goes through a rising-edge detector on `clk`.
  - Any edge loads a 1-entry pending register: valid bit plus direction.
  - Priority when several edges land in the same cycle: up > down > left > right.
  - A new edge overwrites an existing pending entry, whatever the state.
- **States:** IDLE, HOP, DEAD, GAME_OVER.
- **IDLE**
  - On `tick` with pending valid: `facing` <= pending direction and pending is cleared.
  - If the move is legal: enter HOP, apply the first increment on this tick, hop counter = 1.
  - If the move is illegal: only `facing` changes and the state stays IDLE.
- **Legality**, with 11-bit arithmetic so nothing wraps:
  - up: `frog_y - STEP >= Y_MIN`
  - down: `frog_y + STEP <= Y_MAX`
  - left: `frog_x - STEP >= X_MIN`
  - right: `frog_x + STEP <= X_MAX`
- **HOP**
  - Each `tick` moves the frog by `STEP/HOP_FRAMES` in `facing`.
  - After `HOP_FRAMES` increments the state returns to IDLE on that same tick.
  - The pending entry is retained and served on the next IDLE tick.
- **kill** in IDLE or HOP
  - Enter DEAD; position freezes and `hopping` drops.
  - `lives` decrements; if it becomes 0, enter GAME_OVER instead of DEAD.
  - `kill` in DEAD or GAME_OVER is ignored.
- **DEAD**
  - Counts `DEAD_FRAMES` ticks.
  - On the last tick: position <= start, `facing` <= up, pending cleared, go to IDLE.
- **GAME_OVER**
  - Outputs hold.
  - Only `rst_n` exits.

## Timing
- All outputs are registered.
- Reset values:
  - `frog_x = START_X`, `frog_y = START_Y`, `facing = 00`
  - `hopping = 0`, `dead = 0`, `lives = 3`, `game_over = 0`
  - pending cleared, state IDLE
- Press to pending: 1 cycle after the button rises. Pending to motion: the next `tick`.
- Position changes only in the cycle after a `tick`; this includes respawn.
- `kill` and `tick` in the same cycle: `kill` wins and no movement is applied.
- Reset mid-hop: full reset values on the next edge; partial hop is discarded.
- A `tick` arriving the same cycle as a press edge does not consume that press; it is served on the following tick.

## Configuration
- Macro: `FROG_SMOOTH_HOP_EN`.
- Defined: multi-frame hop as described above.
- Undefined:
  - The full `STEP` is applied on the accepting tick.
  - `hopping` is a one-cycle pulse.
  - The HOP state is not built and `HOP_FRAMES` is unused.

## Structure
- Shared package `frogger_pkg`:
  - `facing_t` enum (UP, RIGHT, DOWN, LEFT with the encodings above).
  - `frog_state_t` enum.
  - Screen-size constants.
  - The sprite generator imports `facing_t` from here as well.
- Sub-module `btn_edge`: registered rising-edge detector, instantiated four times.

## Test plan
- Reset, press `btn_up`, give 4 ticks: `frog_y` steps 448→440→432→424→416. `hopping` is high for 4 ticks, `facing = 00`.
- From spawn (448), press `btn_down` and tick: `facing = 10`, `frog_y` stays 448, `hopping` stays 0.
- Press left then right mid-hop: only right remains pending, and it executes on the first tick after the hop ends.
- `kill` coincident with the 2nd hop tick: `frog_y` frozen at 440, `dead = 1`, `lives = 2`. After 60 ticks: position (304, 448), `facing = 00`.
- Three kills: `lives = 0`, `game_over = 1`. Buttons and ticks cause no change until `rst_n` is low for one cycle.
- With `FROG_SMOOTH_HOP_EN` undefined: one up press plus a tick gives `frog_y` 448→416 in a single tick, with a one-cycle `hopping` pulse.

Source files
------------

// File: rtl/frogger_pkg.sv
// frogger_pkg: shared types and playfield geometry for the frog logic.
// Exports facing_t (also used by the frog sprite generator), frog_state_t,
// screen-size constants and two helpers that work out hop legality and the
// position after a hop.
package frogger_pkg;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int FROG_SIZE   = 32;
    localparam int STEP        = 32;
    localparam int HOP_FRAMES  = 4;
    localparam int HOP_INC     = STEP / HOP_FRAMES;
    localparam int X_MIN       = 0;
    localparam int X_MAX       = SCREEN_W - FROG_SIZE;
    localparam int Y_MIN       = 0;
    localparam int Y_MAX       = SCREEN_H - FROG_SIZE;
    localparam int START_X     = 304;
    localparam int START_Y     = 448;
    localparam int DEAD_FRAMES = 60;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        RIGHT = 2'b01,
        DOWN  = 2'b10,
        LEFT  = 2'b11
    } facing_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOP,
        ST_DEAD,
        ST_GAME_OVER
    } frog_state_t;

    // A whole STEP has to fit inside the bounds. The comparison is done in
    // 11 bits and rearranged so that no subtraction can wrap below zero.
    function automatic logic move_legal(logic [9:0] x, logic [9:0] y, facing_t dir);
        logic [10:0] x11;
        logic [10:0] y11;
        logic        ok;
        x11 = {1'b0, x};
        y11 = {1'b0, y};
        case (dir)
            UP:      ok = (y11 >= 11'(Y_MIN + STEP));
            DOWN:    ok = (y11 + 11'(STEP) <= 11'(Y_MAX));
            LEFT:    ok = (x11 >= 11'(X_MIN + STEP));
            default: ok = (x11 + 11'(STEP) <= 11'(X_MAX));
        endcase
        return ok;
    endfunction

    // Returns {x, y} after moving amt pixels toward dir.
    function automatic logic [19:0] move_xy(logic [9:0] x, logic [9:0] y, facing_t dir,
                                            logic [9:0] amt);
        logic [9:0] nx;
        logic [9:0] ny;
        nx = x;
        ny = y;
        case (dir)
            UP:      ny = y - amt;
            DOWN:    ny = y + amt;
            LEFT:    nx = x - amt;
            default: nx = x + amt;
        endcase
        return {nx, ny};
    endfunction

endpackage

// File: rtl/frog_ctrl_if.sv
// frog_ctrl_if: frog controller bus.
//   Inputs to the controller: tick (frame pulse), btn_up/down/left/right
//   (synchronized levels), kill (collision pulse).
//   Outputs from the controller: frog_x, frog_y, facing, hopping, dead,
//   lives, game_over.
// master = stimulus/collision side, slave = the controller.
interface frog_ctrl_if;
    logic       tick;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       kill;
    logic [9:0] frog_x;
    logic [9:0] frog_y;
    logic [1:0] facing;
    logic       hopping;
    logic       dead;
    logic [1:0] lives;
    logic       game_over;

    modport master (
        output tick, btn_up, btn_down, btn_left, btn_right, kill,
        input  frog_x, frog_y, facing, hopping, dead, lives, game_over
    );

    modport slave (
        input  tick, btn_up, btn_down, btn_left, btn_right, kill,
        output frog_x, frog_y, facing, hopping, dead, lives, game_over
    );
endinterface

// File: rtl/frog_ctrl_btn_edge.sv
// btn_edge: rising-edge detector for one synchronized button level.
//   clk, rst_n : clock, synchronous active-low reset
//   btn        : button level
//   rise       : high for the one cycle in which btn is high and was low on
//                the previous cycle
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);
    logic prev;

    always_ff @(posedge clk) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= btn;
    end

    assign rise = btn & ~prev;
endmodule

// File: rtl/frog_ctrl.sv
// frog_ctrl: frog movement controller. Button presses become hops that are
// applied on frame ticks, hops are rejected at the playfield edges, and
// collisions sequence death, respawn and the lives count.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : frog_ctrl_if.slave (tick, buttons, kill in;
//                frog_x/frog_y/facing/hopping/dead/lives/game_over out)
// Macro FROG_SMOOTH_HOP_EN: when defined, a hop is spread over HOP_FRAMES
// ticks. When undefined, the whole STEP is applied on the tick that accepts
// the hop and hopping is a one-cycle pulse.
//
// state        | meaning
// ST_IDLE      | waiting for a tick with a press pending
// ST_HOP       | mid-hop, one increment per tick (smooth build only)
// ST_DEAD      | frozen, counting ticks until respawn
// ST_GAME_OVER | out of lives, held until reset
module frog_ctrl
    import frogger_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    frog_ctrl_if.slave  bus
);
    localparam int DW = $clog2(DEAD_FRAMES + 1);

    logic        rise_up, rise_down, rise_left, rise_right;
    frog_state_t state_q, state_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    facing_t     face_q, face_d;
    logic        hop_q, hop_d, dead_q, dead_d, go_q, go_d;
    logic [1:0]  lives_q, lives_d;
    logic        pend_v_q, pend_v_d, pend_clr;
    facing_t     pend_dir_q, pend_dir_d;
    logic [DW-1:0] dead_cnt_q, dead_cnt_d;
`ifdef FROG_SMOOTH_HOP_EN
    localparam int HW = $clog2(HOP_FRAMES);
    logic [HW-1:0] hop_left_q, hop_left_d;
`endif

    btn_edge u_edge_up    (.clk(clk), .rst_n(rst_n), .btn(bus.btn_up),    .rise(rise_up));
    btn_edge u_edge_down  (.clk(clk), .rst_n(rst_n), .btn(bus.btn_down),  .rise(rise_down));
    btn_edge u_edge_left  (.clk(clk), .rst_n(rst_n), .btn(bus.btn_left),  .rise(rise_left));
    btn_edge u_edge_right (.clk(clk), .rst_n(rst_n), .btn(bus.btn_right), .rise(rise_right));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            x_q        <= 10'(START_X);
            y_q        <= 10'(START_Y);
            face_q     <= UP;
            hop_q      <= 1'b0;
            dead_q     <= 1'b0;
            go_q       <= 1'b0;
            lives_q    <= 2'd3;
            pend_v_q   <= 1'b0;
            pend_dir_q <= UP;
            dead_cnt_q <= '0;
`ifdef FROG_SMOOTH_HOP_EN
            hop_left_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            face_q     <= face_d;
            hop_q      <= hop_d;
            dead_q     <= dead_d;
            go_q       <= go_d;
            lives_q    <= lives_d;
            pend_v_q   <= pend_v_d;
            pend_dir_q <= pend_dir_d;
            dead_cnt_q <= dead_cnt_d;
`ifdef FROG_SMOOTH_HOP_EN
            hop_left_q <= hop_left_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        face_d     = face_q;
        hop_d      = 1'b0;
        lives_d    = lives_q;
        dead_cnt_d = dead_cnt_q;
        pend_clr   = 1'b0;
`ifdef FROG_SMOOTH_HOP_EN
        hop_left_d = hop_left_q;
`endif

        case (state_q)
            ST_IDLE, ST_HOP: begin
                // kill beats a coincident tick: no movement on that frame
                if (bus.kill) begin
                    lives_d = lives_q - 2'd1;
                    if (lives_q == 2'd1) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        state_d    = ST_DEAD;
                        dead_cnt_d = DW'(DEAD_FRAMES);
                    end
                end else if (bus.tick) begin
                    if (state_q == ST_IDLE) begin
                        if (pend_v_q) begin
                            face_d   = pend_dir_q;
                            pend_clr = 1'b1;
                            if (move_legal(x_q, y_q, pend_dir_q)) begin
`ifdef FROG_SMOOTH_HOP_EN
                                {x_d, y_d} = move_xy(x_q, y_q, pend_dir_q, 10'(HOP_INC));
                                hop_left_d = HW'(HOP_FRAMES - 1);
                                state_d    = ST_HOP;
`else
                                {x_d, y_d} = move_xy(x_q, y_q, pend_dir_q, 10'(STEP));
                                hop_d      = 1'b1;
`endif
                            end
                        end
                    end else begin
`ifdef FROG_SMOOTH_HOP_EN
                        // pending press is left alone until the hop completes
                        {x_d, y_d} = move_xy(x_q, y_q, face_q, 10'(HOP_INC));
                        hop_left_d = hop_left_q - HW'(1);
                        if (hop_left_q == HW'(1)) state_d = ST_IDLE;
`endif
                    end
                end
            end
            ST_DEAD: begin
                if (bus.tick) begin
                    dead_cnt_d = dead_cnt_q - DW'(1);
                    if (dead_cnt_q == DW'(1)) begin
                        x_d      = 10'(START_X);
                        y_d      = 10'(START_Y);
                        face_d   = UP;
                        pend_clr = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: ;
        endcase

`ifdef FROG_SMOOTH_HOP_EN
        hop_d = (state_d == ST_HOP);
`endif
        dead_d = (state_d == ST_DEAD);
        go_d   = (state_d == ST_GAME_OVER);

        // a fresh edge always replaces the entry, even one consumed this cycle
        pend_v_d   = pend_v_q & ~pend_clr;
        pend_dir_d = pend_dir_q;
        if (rise_up | rise_down | rise_left | rise_right) begin
            pend_v_d   = 1'b1;
            pend_dir_d = rise_up ? UP : rise_down ? DOWN : rise_left ? LEFT : RIGHT;
        end
    end

    assign bus.frog_x    = x_q;
    assign bus.frog_y    = y_q;
    assign bus.facing    = face_q;
    assign bus.hopping   = hop_q;
    assign bus.dead      = dead_q;
    assign bus.lives     = lives_q;
    assign bus.game_over = go_q;
endmodule

// File: tb/tb_frog_ctrl.sv
module tb_frog_ctrl;
    localparam int T_STEP   = 32;
    localparam int T_HOPF   = 4;
    localparam int T_SX     = 304;
    localparam int T_SY     = 448;
    localparam int T_XMAX   = 608;
    localparam int T_YMAX   = 448;
    localparam int T_DEADF  = 60;
`ifdef FROG_SMOOTH_HOP_EN
    localparam bit SMOOTH   = 1'b1;
    localparam int FIRST    = T_STEP / T_HOPF;
`else
    localparam bit SMOOTH   = 1'b0;
    localparam int FIRST    = T_STEP;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    frog_ctrl_if bus();

    frog_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // reference model: position, lives, remaining dead/hop ticks, pending press
    int m_x, m_y, m_face, m_lives, m_dead_left, m_hop_left, m_pd;
    bit m_over, m_pulse, m_pv;
    bit [3:0] m_prev;

    function automatic bit m_legal(int d);
        case (d)
            0:       return (m_y - T_STEP) >= 0;
            2:       return (m_y + T_STEP) <= T_YMAX;
            3:       return (m_x - T_STEP) >= 0;
            default: return (m_x + T_STEP) <= T_XMAX;
        endcase
    endfunction

    task automatic m_move(int d, int a);
        if (d == 0) m_y -= a;
        else if (d == 2) m_y += a;
        else if (d == 3) m_x -= a;
        else m_x += a;
    endtask

    task automatic model_step(bit r, bit t, bit [3:0] btn, bit k);
        bit [3:0] e;
        bit clr;
        if (!r) begin
            m_x = T_SX; m_y = T_SY; m_face = 0; m_lives = 3; m_dead_left = 0;
            m_hop_left = 0; m_over = 0; m_pulse = 0; m_pv = 0; m_pd = 0; m_prev = 0;
            return;
        end
        e = btn & ~m_prev;
        m_prev = btn;
        clr = 0;
        m_pulse = 0;
        if (m_over) begin
        end else if (m_dead_left > 0) begin
            if (t) begin
                m_dead_left--;
                if (m_dead_left == 0) begin
                    m_x = T_SX; m_y = T_SY; m_face = 0; clr = 1;
                end
            end
        end else if (k) begin
            m_lives--;
            m_hop_left = 0;
            if (m_lives == 0) m_over = 1;
            else m_dead_left = T_DEADF;
        end else if (t) begin
            if (m_hop_left > 0) begin
                m_move(m_face, T_STEP / T_HOPF);
                m_hop_left--;
            end else if (m_pv) begin
                m_face = m_pd;
                clr = 1;
                if (m_legal(m_pd)) begin
                    if (SMOOTH) begin
                        m_move(m_pd, T_STEP / T_HOPF);
                        m_hop_left = T_HOPF - 1;
                    end else begin
                        m_move(m_pd, T_STEP);
                        m_pulse = 1;
                    end
                end
            end
        end
        if (clr) m_pv = 0;
        if (e != 0) begin
            m_pv = 1;
            m_pd = e[3] ? 0 : e[2] ? 2 : e[1] ? 3 : 1;
        end
    endtask

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(string n, int ex, int ey, int ef, int eh, int ed, int el, int eg);
        chk({n, ".x"}, int'(bus.frog_x), ex);
        chk({n, ".y"}, int'(bus.frog_y), ey);
        chk({n, ".facing"}, int'(bus.facing), ef);
        chk({n, ".hopping"}, int'(bus.hopping), eh);
        chk({n, ".dead"}, int'(bus.dead), ed);
        chk({n, ".lives"}, int'(bus.lives), el);
        chk({n, ".game_over"}, int'(bus.game_over), eg);
    endtask

    task automatic cmp_model(int cyc);
        int eh;
        eh = SMOOTH ? int'(m_hop_left > 0) : int'(m_pulse);
        total++;
        if (int'(bus.frog_x) != m_x || int'(bus.frog_y) != m_y || int'(bus.facing) != m_face ||
            int'(bus.hopping) != eh || int'(bus.dead) != int'(m_dead_left > 0) ||
            int'(bus.lives) != m_lives || bus.game_over != m_over) begin
            bad++;
            $display("FAIL model cyc=%0d got x=%0d y=%0d f=%0d h=%0d d=%0d l=%0d g=%0d expected x=%0d y=%0d f=%0d h=%0d d=%0d l=%0d g=%0d",
                     cyc, bus.frog_x, bus.frog_y, bus.facing, bus.hopping, bus.dead, bus.lives,
                     bus.game_over, m_x, m_y, m_face, eh, int'(m_dead_left > 0), m_lives, m_over);
        end
    endtask

    int cyc = 0;

    task automatic step(bit r, bit t, bit u, bit d, bit l, bit rt, bit k);
        rst_n = r;
        bus.tick = t; bus.btn_up = u; bus.btn_down = d;
        bus.btn_left = l; bus.btn_right = rt; bus.kill = k;
        @(posedge clk);
        model_step(r, t, {u, d, l, rt}, k);
        #1;
        cmp_model(cyc);
        cyc++;
    endtask

    typedef struct {
        bit r, t, u, d, l, rt, k;
        int ex, ey, ef, eh, ed, el, eg;
        string name;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bus.tick = 0; bus.btn_up = 0; bus.btn_down = 0;
        bus.btn_left = 0; bus.btn_right = 0; bus.kill = 0;

        vecs[0] = '{0,0,0,0,0,0,0, T_SX, T_SY,         0, 0, 0, 3, 0, "reset"};
        vecs[1] = '{1,0,0,1,0,0,0, T_SX, T_SY,         0, 0, 0, 3, 0, "press_down"};
        vecs[2] = '{1,1,0,0,0,0,0, T_SX, T_SY,         2, 0, 0, 3, 0, "down_illegal"};
        vecs[3] = '{1,0,1,0,0,0,0, T_SX, T_SY,         2, 0, 0, 3, 0, "press_up"};
        vecs[4] = '{1,1,0,0,0,0,0, T_SX, T_SY - FIRST, 0, 1, 0, 3, 0, "up_tick"};
        vecs[5] = '{1,1,0,0,0,0,1, T_SX, T_SY - FIRST, 0, 0, 1, 2, 0, "kill_with_tick"};
        vecs[6] = '{1,0,0,0,0,0,1, T_SX, T_SY - FIRST, 0, 0, 1, 2, 0, "kill_in_dead"};
        vecs[7] = '{1,0,0,0,1,0,0, T_SX, T_SY - FIRST, 0, 0, 1, 2, 0, "press_in_dead"};

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].r, vecs[i].t, vecs[i].u, vecs[i].d, vecs[i].l, vecs[i].rt, vecs[i].k);
            chk_all(vecs[i].name, vecs[i].ex, vecs[i].ey, vecs[i].ef, vecs[i].eh,
                    vecs[i].ed, vecs[i].el, vecs[i].eg);
        end

        // respawn after DEAD_FRAMES ticks; the press made while dead is dropped
        for (int i = 0; i < T_DEADF - 1; i++) step(1, 1, 0, 0, 0, 0, 0);
        chk_all("dead_59", T_SX, T_SY - FIRST, 0, 0, 1, 2, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        chk_all("respawn", T_SX, T_SY, 0, 0, 0, 2, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        chk_all("pending_cleared", T_SX, T_SY, 0, 0, 0, 2, 0);

        // hop, then left then right pressed during/after it: only right runs
        step(1, 0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        chk_all("hop1", T_SX, T_SY - FIRST, 0, 1, 0, 2, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk_all("overwrite", T_SX, T_SY - FIRST, 0, int'(SMOOTH), 0, 2, 0);
`ifdef FROG_SMOOTH_HOP_EN
        step(1, 1, 0, 0, 0, 0, 0);
        chk_all("hop2", T_SX, 432, 0, 1, 0, 2, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        chk_all("hop3", T_SX, 424, 0, 1, 0, 2, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        chk_all("hop4", T_SX, 416, 0, 0, 0, 2, 0);
`endif
        step(1, 1, 0, 0, 0, 0, 0);
        chk_all("right_after_hop", T_SX + FIRST, 416, 1, 1, 0, 2, 0);
        for (int i = 0; i < 8; i++) step(1, i % 2 == 0, 0, 0, 0, 0, 0);

        // two more kills lead to game over; nothing moves afterwards
        step(1, 0, 0, 0, 0, 0, 1);
        chk_all("kill2", T_SX + T_STEP, 416, 1, 0, 1, 1, 0);
        for (int i = 0; i < T_DEADF; i++) step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        chk_all("game_over", T_SX, T_SY, 0, 0, 0, 0, 1);
        step(1, 0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0);
        chk_all("game_over_hold", T_SX, T_SY, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk_all("reset_exit", T_SX, T_SY, 0, 0, 0, 3, 0);

        // reset in the middle of a hop discards it
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        chk_all("reset_mid_hop", T_SX, T_SY, 0, 0, 0, 3, 0);

        // randomized traffic against the model
        begin
            bit [3:0] btn;
            btn = 0;
            for (int i = 0; i < 6000; i++) begin
                bit t, k, r;
                for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) == 0) btn[b] = ~btn[b];
                t = ($urandom_range(0, 3) == 0);
                k = ($urandom_range(0, 149) == 0);
                r = ($urandom_range(0, 1499) != 0);
                step(r, t, btn[3], btn[2], btn[1], btn[0], k);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
